inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage. It holds the program counter and issues word fetches to instruction memory over a req/ack handshake. It presents each fetched instruction and its PC to the IF/ID pipeline register, which captures them on every clock edge where `stall` is low. It also honours back-pressure (`stall`) and control-flow redirects from later stages, inserting NOP bubbles whenever no valid instruction is available.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: IF/ID hold request; while high, the presented instruction is not consumed.
- `redirect_valid` in 1: branch/jump/exception redirect.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (forced to 0).
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch word address (byte address, [1:0]=0).
- `imem_ack` in 1: memory returns data this cycle for the outstanding request.
- `imem_rdata` in 32: fetched word, valid when `imem_ack`=1.
- `inst` out 32: instruction to IF/ID.
- `pc_addr` out 32: PC of `inst`.
- `fetch_wait` out 1: high when `inst` is a bubble because data is not available (RUN without ack, or DRAIN).

## Operation
- The memory protocol is a single outstanding request. Once `imem_req` is raised, `imem_req` and `imem_addr` stay stable until the cycle `imem_ack`=1. `imem_ack` is never asserted without `imem_req`.
- Registers:
  - `pc`: 32-bit.
  - `hold_inst`, `hold_pc`: 32-bit each.
  - `target`: 32-bit.
  - `state`: one of {RUN, HOLD, DRAIN}.
- The bubble is `inst`=32'h0000_0000 (NOP) with `pc_addr`=`pc`.
- RUN: `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ack`=1: `inst`=`imem_rdata`, `pc_addr`=`pc` (combinational pass-through).
    - `stall`=0: `pc`<=`pc`+4; stay in RUN.
    - `stall`=1: `hold_inst`<=`imem_rdata`, `hold_pc`<=`pc`; go to HOLD.
  - `imem_ack`=0: output the bubble; stay in RUN.
- HOLD: `imem_req`=0; `inst`=`hold_inst`, `pc_addr`=`hold_pc`.
  - `stall`=0: `pc`<=`hold_pc`+4; go to RUN.
- DRAIN: `imem_req`=1 with the old `imem_addr`; output the bubble.
  - `imem_ack`=1: discard the data, `pc`<=`target`; go to RUN.
- `redirect_valid` has priority over `stall` and normal advance in every state. The bubble is output that cycle and the ack data is discarded.
  - RUN with `imem_ack`=1, or HOLD: `pc`<=`redirect_pc`&~3; go to RUN. In HOLD the buffer is dropped.
  - RUN with `imem_ack`=0: `target`<=`redirect_pc`&~3; go to DRAIN, because the request must complete.
  - DRAIN: `target` is overwritten with the newest redirect. If `imem_ack`=1 in the same cycle, `pc`<=new target and go to RUN.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async, held): `state`=RUN, `pc`=`RESET_PC`, `hold_*`=0, `target`=0.
  - Outputs forced to `imem_req`=0, `inst`=0, `pc_addr`=`RESET_PC`, `fetch_wait`=0.
  - First request is issued in the first cycle after `rst` deasserts.
- Memory ack in the same cycle as the request: a zero-bubble steady state, one instruction per cycle.
- Latency from `imem_ack` to the IF/ID capture edge is 0 cycles (same edge) when `stall`=0.
- A redirect in cycle N produces a request to the target in cycle N+1. Exception: RUN without ack, or DRAIN, delays it until the old ack arrives.
- Reset mid-request abandons the request; the memory side must also reset.
- `stall` while a bubble is output has no effect on `pc`.

## Structure
- Shared package (`common_def`) holds:
  - `COMMON_WIDTH` (32)
  - `NOP_INST` = 32'h0
  - `INST_BYTES` = 4
  - `fetch_state_t` enum {RUN, HOLD, DRAIN}
- No sub-module. The block is one FSM plus the PC and hold registers, with a combinational output mux.

## Test plan
- Reset release, memory always acks, `stall`=0 → `imem_addr` and `pc_addr` go 0, 4, 8, 12 on consecutive cycles; `inst` equals the data returned for each address.
- Ack at addr 8 with `stall`=1 for 3 cycles → state HOLD, `imem_req`=0, `inst`/`pc_addr` hold (data@8, 8). After `stall` falls, the next request is to 12.
- Memory 2-cycle latency, redirect to 32'h100 in the first wait cycle of the fetch at 0x10 → `imem_addr` stays 0x10 until ack. That data is dropped and the next request is 0x100; bubbles throughout with `fetch_wait`=1.
- Redirect to 32'h203 while in HOLD → buffer dropped, next request 0x200, bubble that cycle.
- Redirect in the same cycle as an ack with `stall`=1 → redirect wins: no HOLD entry, next request at the target.
- `pc`=32'hFFFF_FFFC, ack with no stall → next request address 0; `rst` pulse mid-fetch → `imem_req`=0 immediately, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, the NOP encoding
// and the fetch FSM state type.
package common_def;

    localparam int          COMMON_WIDTH = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES   = 32'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic logic [COMMON_WIDTH-1:0] word_align(input logic [COMMON_WIDTH-1:0] a);
        return {a[COMMON_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus: one outstanding word fetch at a time.
interface inst_fetch_if;
    import common_def::*;

    logic                    imem_req;
    logic [COMMON_WIDTH-1:0] imem_addr;
    logic                    imem_ack;
    logic [COMMON_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, hold buffer and redirect drain FSM feeding the
// IF/ID register, with NOP bubbles whenever no valid instruction is available.
module inst_fetch
    import common_def::*;
#(
    parameter logic [COMMON_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [COMMON_WIDTH-1:0] redirect_pc,
    inst_fetch_if.master            imem,
    output logic [COMMON_WIDTH-1:0] inst,
    output logic [COMMON_WIDTH-1:0] pc_addr,
    output logic                    fetch_wait
);

    fetch_state_t            state_q, state_d;
    logic [COMMON_WIDTH-1:0] pc_q, pc_d;
    logic [COMMON_WIDTH-1:0] hold_inst_q, hold_inst_d;
    logic [COMMON_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [COMMON_WIDTH-1:0] target_q, target_d;
    logic [COMMON_WIDTH-1:0] redir_pc;

    assign redir_pc = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            target_q    <= target_d;
        end
    end

    // Redirect beats stall and normal advance; without an ack the open request
    // must still complete, so the target is parked until DRAIN sees the ack.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        target_d    = target_q;
        unique case (state_q)
            RUN: begin
                if (imem.imem_ack) begin
                    if (redirect_valid) begin
                        pc_d = redir_pc;
                    end else if (!stall) begin
                        pc_d = pc_q + INST_BYTES;
                    end else begin
                        hold_inst_d = imem.imem_rdata;
                        hold_pc_d   = pc_q;
                        state_d     = HOLD;
                    end
                end else if (redirect_valid) begin
                    target_d = redir_pc;
                    state_d  = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = RUN;
                end else if (!stall) begin
                    pc_d    = hold_pc_q + INST_BYTES;
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    target_d = redir_pc;
                end
                if (imem.imem_ack) begin
                    pc_d    = redirect_valid ? redir_pc : target_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // pc_q is frozen in DRAIN, so it doubles as the still-open request address.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        inst           = NOP_INST;
        pc_addr        = pc_q;
        fetch_wait     = 1'b0;
        unique case (state_q)
            RUN: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack && !redirect_valid) begin
                    inst = imem.imem_rdata;
                end
                fetch_wait = !imem.imem_ack;
            end
            HOLD: begin
                if (!redirect_valid) begin
                    inst    = hold_inst_q;
                    pc_addr = hold_pc_q;
                end
            end
            DRAIN: begin
                imem.imem_req = 1'b1;
                fetch_wait    = 1'b1;
            end
            default: begin
                imem.imem_req = 1'b0;
            end
        endcase
        if (rst) begin
            imem.imem_req = 1'b0;
            inst          = NOP_INST;
            pc_addr       = RESET_PC;
            fetch_wait    = 1'b0;
        end
    end

endmodule
